// File: rtl/match_log_pkg.sv
// -----------------------------------------------------------------------------
// match_log_pkg
// Shared constants for the match event logger: default widths and depth, the
// record width (a record is packed as {ovf, gap}), and the saturation maxima of
// the gap measurement and the total-match counter.
// -----------------------------------------------------------------------------
package match_log_pkg;

    localparam int GAP_W_DEF = 8;
    localparam int CNT_W_DEF = 16;
    localparam int DEPTH_DEF = 4;

    // One FIFO record: {ovf, gap}.
    localparam int REC_W_DEF = GAP_W_DEF + 1;

    localparam int GAP_MAX_DEF = (1 << GAP_W_DEF) - 1;
    localparam int CNT_MAX_DEF = (1 << CNT_W_DEF) - 1;

endpackage : match_log_pkg

// File: rtl/event_fifo.sv
// -----------------------------------------------------------------------------
// event_fifo
// Synchronous first-word-fall-through FIFO, WIDTH x DEPTH (DEPTH a power of 2,
// at least 2). The head entry is visible on data_o whenever empty_o is low.
//
// Ports:
//   clk      in   clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   flush_i  in   synchronous flush, beats push and pop
//   push_i   in   write data_i; accepted when not full, or full with a pop
//   data_i   in   WIDTH  record to write
//   pop_i    in   advance the head; ignored while empty
//   data_o   out  WIDTH  head record, zero while empty
//   full_o   out  FIFO full
//   empty_o  out  FIFO empty
// -----------------------------------------------------------------------------
module event_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    // One extra pointer bit separates full from empty when the indices match.
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    // A full FIFO can still take a write when the head leaves on the same edge.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
        end
    end

    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // NOTE: storage has no reset; empty pointers gate data_o, so stale words are never visible.
    always_ff @(posedge clk) begin
        if (do_push && !flush_i) begin
            mem_q[wr_ptr_q[AW-1:0]] <= data_i;
        end
    end

endmodule : event_fifo

// File: rtl/match_event_logger.sv
// -----------------------------------------------------------------------------
// match_event_logger
// Logs match events from a serial sequence detector. Each det_in=1 edge is an
// event; the logger measures the number of edges since the previous event,
// queues {ovf, gap} records in an FWFT FIFO, counts logged events and flags
// records lost to a full FIFO.
//
// Ports:
//   clk        in   clock, rising edge
//   reset      in   asynchronous active-low reset
//   det_in     in   detector match output, one event per high edge
//   en         in   logging enable (FIFO push and total_cnt)
//   clr        in   synchronous clear of all logging state
//   rec_ready  in   consumer takes the head record
//   rec_valid  out  a record is available
//   rec_gap    out  GAP_W  gap of the head record
//   rec_ovf    out  head record gap saturated
//   total_cnt  out  CNT_W  saturating count of events logged with en=1
//   dropped    out  sticky: a record was lost to a full FIFO
// -----------------------------------------------------------------------------
module match_event_logger
    import match_log_pkg::*;
#(
    parameter int GAP_W = GAP_W_DEF,
    parameter int CNT_W = CNT_W_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             det_in,
    input  logic             en,
    input  logic             clr,
    input  logic             rec_ready,
    output logic             rec_valid,
    output logic [GAP_W-1:0] rec_gap,
    output logic             rec_ovf,
    output logic [CNT_W-1:0] total_cnt,
    output logic             dropped
);

    localparam int               REC_W   = GAP_W + 1;
    localparam logic [GAP_W-1:0] GAP_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
    logic [CNT_W-1:0] total_q, total_d;
    logic             dropped_q, dropped_d;

    logic [GAP_W:0]   gap_inc;
    logic [GAP_W-1:0] gap_sat;
    logic             gap_ovf;
    logic             push;
    logic             pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [REC_W-1:0] rec_in;
    logic [REC_W-1:0] rec_out;

    always_comb begin
        // The extra bit of gap_inc lets the overflow test see gap_cnt+1 unclipped.
        gap_inc = {1'b0, gap_cnt_q} + (GAP_W+1)'(1);
        gap_sat = (gap_cnt_q == GAP_MAX) ? GAP_MAX : gap_inc[GAP_W-1:0];
        gap_ovf = (gap_inc >= {1'b0, GAP_MAX});
        rec_in  = {gap_ovf, gap_sat};

        // clr masks both the event and the consumer handshake on its edge.
        push = det_in && en && !clr;
        pop  = !fifo_empty && rec_ready && !clr;

        gap_cnt_d = gap_sat;
        total_d   = total_q;
        dropped_d = dropped_q;
        if (clr) begin
            gap_cnt_d = '0;
            total_d   = '0;
            dropped_d = 1'b0;
        end else begin
            // Events restart the gap measurement even while logging is disabled.
            if (det_in) gap_cnt_d = '0;
            if (push && (total_q != CNT_MAX)) total_d = total_q + CNT_W'(1);
            if (push && fifo_full && !pop) dropped_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            gap_cnt_q <= '0;
            total_q   <= '0;
            dropped_q <= 1'b0;
        end else begin
            gap_cnt_q <= gap_cnt_d;
            total_q   <= total_d;
            dropped_q <= dropped_d;
        end
    end

    event_fifo #(
        .WIDTH (REC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (reset),
        .flush_i (clr),
        .push_i  (push),
        .data_i  (rec_in),
        .pop_i   (pop),
        .data_o  (rec_out),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign rec_valid = !fifo_empty;
    assign rec_gap   = rec_out[GAP_W-1:0];
    assign rec_ovf   = rec_out[GAP_W];
    assign total_cnt = total_q;
    assign dropped   = dropped_q;

endmodule : match_event_logger

// File: tb/tb_match_event_logger.sv
// -----------------------------------------------------------------------------
// tb_match_event_logger
// Directed bench for match_event_logger with default parameters. Inputs change
// 1 time unit after a rising edge; outputs are sampled at the same point.
// -----------------------------------------------------------------------------
module tb_match_event_logger;
    import match_log_pkg::*;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 det_in;
    logic                 en;
    logic                 clr;
    logic                 rec_ready;
    logic                 rec_valid;
    logic [GAP_W_DEF-1:0] rec_gap;
    logic                 rec_ovf;
    logic [CNT_W_DEF-1:0] total_cnt;
    logic                 dropped;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    match_event_logger dut (
        .clk       (clk),
        .reset     (reset),
        .det_in    (det_in),
        .en        (en),
        .clr       (clr),
        .rec_ready (rec_ready),
        .rec_valid (rec_valid),
        .rec_gap   (rec_gap),
        .rec_ovf   (rec_ovf),
        .total_cnt (total_cnt),
        .dropped   (dropped)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One clock edge with the given det_in / rec_ready, then both return low.
    task automatic step(input logic d, input logic rdy);
        det_in    = d;
        rec_ready = rdy;
        tick();
        det_in    = 1'b0;
        rec_ready = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0);
    endtask

    task automatic do_clr();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    task automatic check_head(input string tag, input int gap, input logic ovf);
        check({tag, " valid"}, 32'(rec_valid), 32'd1);
        check({tag, " gap"},   32'(rec_gap),   32'(gap));
        check({tag, " ovf"},   32'(rec_ovf),   32'(ovf));
    endtask

    // Pops the head after checking it.
    task automatic pop_head(input string tag, input int gap, input logic ovf);
        check_head(tag, gap, ovf);
        step(1'b0, 1'b1);
    endtask

    task automatic check_empty(input string tag);
        check({tag, " valid"}, 32'(rec_valid), 32'd0);
        check({tag, " gap"},   32'(rec_gap),   32'd0);
    endtask

    initial begin
        reset = 1'b0; det_in = 1'b0; en = 1'b1; clr = 1'b0; rec_ready = 1'b0;
        #12;
        check_empty("reset");
        check("reset ovf",     32'(rec_ovf),   32'd0);
        check("reset total",   32'(total_cnt), 32'd0);
        check("reset dropped", 32'(dropped),   32'd0);

        // Events at edges 5 and 7 after reset release: gaps 5 and 2.
        @(negedge clk);
        reset = 1'b1;
        idle(4);
        check("pre-event valid", 32'(rec_valid), 32'd0);
        step(1'b1, 1'b0);
        check_head("edge5", 5, 1'b0);
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        check("edge7 total", 32'(total_cnt), 32'd2);
        pop_head("edge7 head", 5, 1'b0);
        pop_head("edge7 second", 2, 1'b0);
        check_empty("edge7 drained");

        // Saturation boundary: gap 254 (no ovf), exactly 255 (ovf), long idle (ovf).
        do_clr();
        idle(253); step(1'b1, 1'b0);
        idle(254); step(1'b1, 1'b0);
        idle(300); step(1'b1, 1'b0);
        pop_head("sat 254", 254, 1'b0);
        pop_head("sat 255", GAP_MAX_DEF, 1'b1);
        pop_head("sat 300", GAP_MAX_DEF, 1'b1);
        check_empty("sat drained");

        // Overflow: 6 events with gaps 1..6 into a depth-4 FIFO.
        do_clr();
        for (int i = 0; i < 6; i++) begin
            idle(i);
            step(1'b1, 1'b0);
        end
        check("ovfl dropped", 32'(dropped),   32'd1);
        check("ovfl total",   32'(total_cnt), 32'd6);
        for (int i = 1; i <= 4; i++) pop_head($sformatf("ovfl drain%0d", i), i, 1'b0);
        check_empty("ovfl drained");
        check("ovfl dropped sticky", 32'(dropped), 32'd1);

        // Full FIFO with push and pop on the same edge: no drop.
        do_clr();
        for (int i = 0; i < 4; i++) begin
            idle(i);
            step(1'b1, 1'b0);
        end
        idle(1);
        step(1'b1, 1'b1);
        check("fullpp dropped", 32'(dropped),   32'd0);
        check("fullpp total",   32'(total_cnt), 32'd5);
        pop_head("fullpp d1", 2, 1'b0);
        pop_head("fullpp d2", 3, 1'b0);
        pop_head("fullpp d3", 4, 1'b0);
        pop_head("fullpp d4", 2, 1'b0);
        check_empty("fullpp drained");

        // Empty FIFO with push and ready on the same edge: push lands, no pop.
        do_clr();
        step(1'b1, 1'b1);
        pop_head("emptypp", 1, 1'b0);
        check_empty("emptypp drained");

        // en=0 event at edge 3 restarts the gap; en=1 event at edge 10 gives gap 7.
        do_clr();
        idle(2);
        en = 1'b0;
        step(1'b1, 1'b0);
        en = 1'b1;
        check("en0 valid", 32'(rec_valid), 32'd0);
        check("en0 total", 32'(total_cnt), 32'd0);
        idle(6);
        step(1'b1, 1'b0);
        check("en1 total", 32'(total_cnt), 32'd1);
        pop_head("en1", 7, 1'b0);
        check_empty("en1 drained");

        // clr coincident with an event wipes everything; next event 4 edges later.
        do_clr();
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
        check("preclr dropped", 32'(dropped), 32'd1);
        det_in = 1'b1;
        do_clr();
        det_in = 1'b0;
        check_empty("clr");
        check("clr total",   32'(total_cnt), 32'd0);
        check("clr dropped", 32'(dropped),   32'd0);
        idle(3);
        step(1'b1, 1'b0);
        check("postclr total", 32'(total_cnt), 32'd1);
        check_head("postclr", 4, 1'b0);

        // Asynchronous reset mid-cycle with records queued.
        idle(2);
        step(1'b1, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        check_empty("async reset");
        check("async reset total", 32'(total_cnt), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        step(1'b1, 1'b0);
        check_head("after reset", 1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_match_event_logger

// File: doc/match_event_logger.md
Name: match_event_logger

Overview:
- Downstream consumer of the serial sequence detector's 1-bit Mealy match output.
- Registers each match event and measures the clock-edge gap since the previous match.
- Queues gap records in a small first-word-fall-through FIFO with a valid/ready read port.
- Keeps a saturating total-match counter and a sticky drop flag for software/monitor logic.

Parameters:
- GAP_W, 8, width of the gap measurement; saturates at 2^GAP_W-1.
- CNT_W, 16, width of the total match counter; saturates at 2^CNT_W-1.
- DEPTH, 4, FIFO entries; must be a power of 2 and at least 2.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- det_in  in  1  detector match output; sampled at each clk rising edge.
- en  in  1  logging enable; gates FIFO push and total_cnt.
- clr  in  1  synchronous clear; highest priority after reset.
- rec_ready  in  1  consumer accepts the head record.
- rec_valid  out  1  FIFO not empty.
- rec_gap  out  GAP_W  gap of the head record.
- rec_ovf  out  1  head record gap saturated.
- total_cnt  out  CNT_W  matches logged while en=1, saturating.
- dropped  out  1  sticky: at least one record lost because the FIFO was full.

Behaviour:
- Reset (reset=0, asynchronous): gap_cnt=0, FIFO empty, rec_valid=0, rec_gap=0, rec_ovf=0, total_cnt=0, dropped=0.
- Event: det_in=1 at a rising edge. Each high edge is one event, so a level held N edges gives N events.
- Gap counter: always runs, independent of en.
  - Non-event edge: gap_cnt <= sat(gap_cnt+1).
  - Event edge: record gap = sat(gap_cnt+1), ovf = 1 when gap_cnt+1 >= 2^GAP_W-1; then gap_cnt <= 0.
  - Worked example: first edge after reset release is edge 1; events at edges 5 and 7 give gaps 5 and 2.
- Push: on an event edge with en=1 and clr=0.
  - FIFO not full: record written.
  - FIFO full with a pop on the same edge: push accepted; occupancy unchanged.
  - FIFO full with no pop: record discarded; dropped <= 1 until clr or reset.
- Pop: rec_valid && rec_ready at an edge advances the head.
  - rec_ready is ignored when rec_valid=0.
  - rec_gap/rec_ovf hold the head entry (first-word fall-through) and are stable while rec_valid=1 and not popped.
- Latency: an event at edge k into an empty FIFO makes rec_valid=1 right after edge k. There is no combinational path from det_in to any output.
- Push and pop on the same edge with the FIFO empty: no pop occurs and the push lands; rec_valid=1 next.
- total_cnt: increments on every event with en=1, including dropped records; holds at max.
- en=0: events still restart gap_cnt but produce no record and no total_cnt increment.
- clr=1 at an edge:
  - empties the FIFO and zeroes gap_cnt, total_cnt and dropped;
  - ignores det_in and rec_ready on that edge;
  - leaves rec_valid=0 after the edge.
- Reset mid-operation: all state returns to reset values immediately; any queued records are lost.
- Pointers are log2(DEPTH)+1 bits wide and wrap naturally. full = MSBs differ and the rest are equal; empty = pointers equal.

Decomposition:
- Shared package match_log_pkg holds:
  - GAP_W/CNT_W/DEPTH defaults;
  - the record width constant REC_W = GAP_W+1, packed as {ovf, gap};
  - the saturation maximum constants.
- One sub-module, event_fifo: a parameterised synchronous FWFT FIFO of REC_W x DEPTH with push, pop, full, empty and a synchronous flush.
- The top level holds the gap counter, event logic, total counter and drop flag.

Test Plan:
- Reset release, en=1, rec_ready=0, det_in high at edges 5 and 7 -> records gap=5 then gap=2, ovf=0, total_cnt=2.
- No events for 300 edges, then one event (GAP_W=8) -> record gap=255, ovf=1.
- rec_ready=0, 6 events with DEPTH=4 -> 4 records retained, dropped=1, total_cnt=6. Draining returns the first 4 gaps in order, then rec_valid=0.
- FIFO full and rec_ready=1 on the same edge as an event -> head popped, new record appended, dropped stays 0.
- en=0 event at edge 3, en=1 event at edge 10 -> one record with gap=7, total_cnt=1.
- Records queued and dropped=1, then clr pulse coincident with det_in=1 -> rec_valid=0, total_cnt=0, dropped=0. The next event at 4 edges after clr records gap=4.
